// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store unit: op codes, access sizes and FSM states.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // req_op = {store, unsigned, size[1:0]}
    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1011;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational byte-lane logic: load extraction/extension, store-lane merge, alignment check.
module mau_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o,
    output logic        misalign_o
);

    logic [4:0]  byte_lsb;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_lsb = {addr_i, 3'b000};
    assign byte_sel = word_i[byte_lsb +: 8];
    assign half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        load_data_o = word_i;
        merged_o    = word_i;
        misalign_o  = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                load_data_o            = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
                merged_o[byte_lsb +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
                misalign_o  = addr_i[0];
                if (addr_i[1]) begin
                    merged_o[31:16] = wdata_i[15:0];
                end else begin
                    merged_o[15:0] = wdata_i[15:0];
                end
            end
            SZ_WORD: begin
                load_data_o = word_i;
                merged_o    = wdata_i;
                misalign_o  = |addr_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-wide memory without byte enables.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; req_ready is high only in IDLE outside reset.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              dm_mem_read,
    output logic              dm_mem_write,
    output logic [ADDR_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_write_data,
    input  logic [DATA_W-1:0] dm_read_data,
    output state_t            dbg_state_o
);

    if (DATA_W != 32) begin : g_width_check
        $error("mem_access_unit: only DATA_W = 32 is supported");
    end

    state_t state_q, state_d;

    logic [DATA_W-1:0] rmw_word_q;
    logic [ADDR_W-1:0] rmw_addr_q;
    logic              rmw_load;

    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic [1:0]        op_size;
    logic              op_store;
    logic              op_err;
    logic              sub_store;
    logic              misalign;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged_word;
    logic [ADDR_W-1:0] word_addr;

    assign op_size   = req_op[1:0];
    assign op_store  = req_op[3];
    assign op_err    = !op_is_legal(req_op) || misalign;
    assign sub_store = op_store && (op_size != SZ_WORD) && !op_err;
    assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

    mau_lane_align u_lane_align (
        .addr_i      (req_addr[1:0]),
        .size_i      (op_size),
        .unsigned_i  (req_op[2]),
        .word_i      (dm_read_data),
        .wdata_i     (req_wdata),
        .load_data_o (load_data),
        .merged_o    (merged_word),
        .misalign_o  (misalign)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid && sub_store) state_d = RMW_WR;
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes follow reset combinationally so nothing reaches memory while it is held.
    always_comb begin
        req_ready     = 1'b0;
        dm_mem_read   = 1'b0;
        dm_mem_write  = 1'b0;
        dm_address    = word_addr;
        dm_write_data = req_wdata;
        rmw_load      = 1'b0;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = '0;
        resp_err_d    = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        if (op_err) begin
                            resp_valid_d = 1'b1;
                            resp_err_d   = 1'b1;
                        end else if (!op_store) begin
                            dm_mem_read  = 1'b1;
                            resp_valid_d = 1'b1;
                            resp_rdata_d = load_data;
                        end else if (op_size == SZ_WORD) begin
                            dm_mem_write = 1'b1;
                            resp_valid_d = 1'b1;
                        end else begin
                            dm_mem_read = 1'b1;
                            rmw_load    = 1'b1;
                        end
                    end
                end
                RMW_WR: begin
                    dm_mem_write  = 1'b1;
                    dm_address    = rmw_addr_q;
                    dm_write_data = rmw_word_q;
                    resp_valid_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rmw_word_q   <= '0;
            rmw_addr_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            if (rmw_load) begin
                rmw_word_q <= merged_word;
                rmw_addr_q <= word_addr;
            end
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference model, per-cycle compare process, directed and random requests.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dm_mem_read;
    logic        dm_mem_write;
    logic [31:0] dm_address;
    logic [31:0] dm_write_data;
    logic [31:0] dm_read_data;
    state_t      dbg_state;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .dm_mem_read   (dm_mem_read),
        .dm_mem_write  (dm_mem_write),
        .dm_address    (dm_address),
        .dm_write_data (dm_write_data),
        .dm_read_data  (dm_read_data),
        .dbg_state_o   (dbg_state)
    );

    // Data memory environment: 16 words, combinational read, write on the rising edge.
    logic [31:0] mem [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [31:0] pl_val = 32'd0;

    assign dm_read_data = mem[dm_address[5:2]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (dm_mem_write) mem[dm_address[5:2]] <= dm_write_data;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: memory as a byte array, expected responses as a timed queue.
    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  ref_bytes [64];
    int          busy_cyc = -1;
    int          pend_addr = 0;
    logic [31:0] pend_word = 32'd0;

    always @(negedge clk) begin
        exp_t        e;
        int          ai, wa, nb, lane;
        logic        legal, err, exp_ready;
        logic [31:0] v;
        logic [7:0]  wb [4];

        if (pl_en) begin
            for (int k = 0; k < 4; k++) ref_bytes[{pl_idx, 2'b00} + k] = pl_val[8*k +: 8];
        end

        if (reset) begin
            check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
            check("rst_resp_rdata", resp_rdata, 32'd0);
            check("rst_resp_err", {31'b0, resp_err}, 32'd0);
            check("rst_req_ready", {31'b0, req_ready}, 32'd0);
            check("rst_dm_strobes", {30'b0, dm_mem_read, dm_mem_write}, 32'd0);
            exp_q.delete();
            busy_cyc = -1;
        end else begin
            exp_ready = (cyc != busy_cyc);
            check("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});

            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                check("resp_valid", {31'b0, resp_valid}, 32'd1);
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
            end else begin
                check("resp_valid_quiet", {31'b0, resp_valid}, 32'd0);
            end

            if (cyc == busy_cyc) begin
                check("rmw_strobes", {30'b0, dm_mem_read, dm_mem_write}, 32'd1);
                check("rmw_address", dm_address, pend_addr);
                check("rmw_wdata", dm_write_data, pend_word);
                for (int k = 0; k < 4; k++) ref_bytes[pend_addr + k] = pend_word[8*k +: 8];
            end else if (req_valid) begin
                ai    = int'(req_addr[5:0]);
                wa    = ai & ~3;
                nb    = (req_op[1:0] == 2'b00) ? 1 : (req_op[1:0] == 2'b01) ? 2 : 4;
                legal = req_op inside {4'b0000, 4'b0001, 4'b0011, 4'b0100,
                                       4'b0101, 4'b1000, 4'b1001, 4'b1011};
                err   = !legal || ((ai % nb) != 0);
                if (err) begin
                    check("err_no_strobes", {30'b0, dm_mem_read, dm_mem_write}, 32'd0);
                    exp_q.push_back('{due: cyc + 1, rdata: 32'd0, err: 1'b1});
                end else if (!req_op[3]) begin
                    check("load_strobes", {30'b0, dm_mem_read, dm_mem_write}, 32'd2);
                    check("load_address", dm_address, wa);
                    v = 32'd0;
                    for (int k = 0; k < nb; k++) v = v | (32'(ref_bytes[ai + k]) << (8 * k));
                    if (!req_op[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
                    exp_q.push_back('{due: cyc + 1, rdata: v, err: 1'b0});
                end else if (nb == 4) begin
                    check("sw_strobes", {30'b0, dm_mem_read, dm_mem_write}, 32'd1);
                    check("sw_address", dm_address, wa);
                    check("sw_wdata", dm_write_data, req_wdata);
                    for (int k = 0; k < 4; k++) ref_bytes[wa + k] = req_wdata[8*k +: 8];
                    exp_q.push_back('{due: cyc + 1, rdata: 32'd0, err: 1'b0});
                end else begin
                    check("rmw_rd_strobes", {30'b0, dm_mem_read, dm_mem_write}, 32'd2);
                    check("rmw_rd_address", dm_address, wa);
                    for (int k = 0; k < 4; k++) wb[k] = ref_bytes[wa + k];
                    lane = ai & 3;
                    for (int k = 0; k < nb; k++) wb[lane + k] = req_wdata[8*k +: 8];
                    pend_word = {wb[3], wb[2], wb[1], wb[0]};
                    pend_addr = wa;
                    busy_cyc  = cyc + 1;
                    exp_q.push_back('{due: cyc + 2, rdata: 32'd0, err: 1'b0});
                end
            end else begin
                check("idle_strobes", {30'b0, dm_mem_read, dm_mem_write}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, output int waited);
        logic ok;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        waited    = 0;
        ok        = 1'b0;
        while (!ok && waited < 20) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!ok) begin
            check("issue_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string name, input int lat, input logic [31:0] rd, input logic er);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            check({name, "_early"}, {31'b0, resp_valid}, 32'd0);
        end
        @(negedge clk);
        check({name, "_valid"}, {31'b0, resp_valid}, 32'd1);
        check({name, "_rdata"}, resp_rdata, rd);
        check({name, "_err"}, {31'b0, resp_err}, {31'b0, er});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int          w, w2;
        logic [3:0]  op;
        logic [31:0] a;
        logic [3:0]  legal_ops [8];
        legal_ops = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1011};

        // Preload both the memory and the reference under reset.
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            pl_en  = 1'b1;
            pl_idx = 4'(i);
            case (i)
                0:       pl_val = 32'h8899AABB;
                1:       pl_val = 32'h12348001;
                2:       pl_val = 32'h11223344;
                4:       pl_val = 32'h01020304;
                default: pl_val = $urandom;
            endcase
            @(posedge clk);
            #1;
        end
        pl_en = 1'b0;
        reset = 1'b0;

        // Byte loads
        issue(4'b0000, 32'h3, 32'h0, w); idle();
        wait_resp("lb_3", 1, 32'hFFFFFF88, 1'b0);
        issue(4'b0100, 32'h3, 32'h0, w); idle();
        wait_resp("lbu_3", 1, 32'h00000088, 1'b0);

        // Halfword loads and a misaligned half
        issue(4'b0001, 32'h4, 32'h0, w); idle();
        wait_resp("lh_4", 1, 32'hFFFF8001, 1'b0);
        issue(4'b0101, 32'h6, 32'h0, w); idle();
        wait_resp("lhu_6", 1, 32'h00001234, 1'b0);
        issue(4'b0001, 32'h5, 32'h0, w); idle();
        wait_resp("lh_5_misaligned", 1, 32'h0, 1'b1);

        // sb read-modify-write, then read back
        issue(4'b1000, 32'h9, 32'hFFFFFFA5, w); idle();
        @(negedge clk);
        check("sb_busy_ready", {31'b0, req_ready}, 32'd0);
        check("sb_busy_write", {31'b0, dm_mem_write}, 32'd1);
        check("sb_busy_wdata", dm_write_data, 32'h1122A544);
        check("sb_busy_state", {31'b0, dbg_state}, {31'b0, RMW_WR});
        @(posedge clk);
        #1;
        wait_resp("sb_9", 1, 32'h0, 1'b0);
        issue(4'b0011, 32'h8, 32'h0, w); idle();
        wait_resp("lw_8_after_sb", 1, 32'h1122A544, 1'b0);

        // Back-to-back sw then lw
        issue(4'b1011, 32'hC, 32'hDEADBEEF, w);
        issue(4'b0011, 32'hC, 32'h0, w2); idle();
        check("b2b_sw_wait", w, 32'd1);
        check("b2b_lw_wait", w2, 32'd1);
        wait_resp("b2b_lw", 1, 32'hDEADBEEF, 1'b0);

        // Errors: illegal op and misaligned sw leave memory alone
        issue(4'b0010, 32'h0, 32'h0, w); idle();
        wait_resp("illegal_op", 1, 32'h0, 1'b1);
        issue(4'b1011, 32'h2, 32'h55555555, w); idle();
        wait_resp("sw_2_misaligned", 1, 32'h0, 1'b1);
        issue(4'b0011, 32'h0, 32'h0, w); idle();
        wait_resp("lw_0_unchanged", 1, 32'h8899AABB, 1'b0);

        // Reset during the RMW write cycle discards the write and the response
        issue(4'b1001, 32'h12, 32'h0000BEEF, w); idle();
        reset = 1'b1;
        @(negedge clk);
        check("midrmw_no_write", {31'b0, dm_mem_write}, 32'd0);
        check("midrmw_no_resp", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);
        check("post_rst_state", {31'b0, dbg_state}, {31'b0, IDLE});
        check("post_rst_no_resp", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        issue(4'b0011, 32'h10, 32'h0, w); idle();
        wait_resp("lw_10_after_rst", 1, 32'h01020304, 1'b0);

        // Random traffic, checked cycle by cycle by the compare process
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 7)];
            else op = 4'($urandom_range(0, 15));
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (op[1:0] == 2'b01) a[0] = 1'b0;
                else if (op[1:0] != 2'b00) a[1:0] = 2'b00;
            end
            issue(op, a, $urandom, w);
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        idle();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("drain_queue", exp_q.size(), 32'd0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("mem_word_%0d", i), mem[i],
                  {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
